// File: rtl/uprj_rst_seq.sv
// Reset sequencer for the user project: synchronises and masks reset requests,
// stretches them, releases domains in order and records the cause.
module uprj_rst_seq #(
    parameter int N_SRC       = 3,
    parameter int N_DOM       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 8,
    parameter int STAGE_GAP   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_rst_src,
    input  logic [N_SRC-1:0] i_src_mask,
    input  logic             i_cause_clr,
    output logic [N_DOM-1:0] o_dom_rst,
    output logic [N_SRC-1:0] o_cause,
    output logic             o_por,
    output logic             o_busy,
    output logic             o_rel_done
);

    localparam int CW = $clog2(STRETCH + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int IW = $clog2(N_DOM + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STRETCH,
        ST_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_DOM-1:0] dom_q, dom_d;
    logic             done_q, done_d;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_d_q;
    logic [N_SRC-1:0] rise;
    logic             active;
    logic [N_SRC-1:0] cause_q;
    logic             por_q;

    assign src_s  = sync_q[SYNC_STAGES-1];
    assign active = |(src_s & ~i_src_mask);
    assign rise   = src_s & ~src_d_q & ~i_src_mask;

    // Per-source synchroniser chain plus one extra flop for rise detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            src_d_q <= '0;
        end else begin
            sync_q[0] <= i_rst_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            src_d_q <= src_s;
        end
    end

    // State register; power-on enters the stretch phase directly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_STRETCH;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
        end
    end

    // Next state; an active request aborts any phase back to HOLD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = 1'b0;
        if (active) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    dom_d = '0;
                end
                ST_HOLD: begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                    dom_d   = '1;
                end
                ST_STRETCH: begin
                    if (cnt_q == CW'(STRETCH - 1)) begin
                        dom_d[0] = 1'b0;
                        cnt_d    = '0;
                        gap_d    = '0;
                        idx_d    = IW'(1);
                        if (N_DOM == 1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_REL;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_REL: begin
                    if (gap_q == GW'(STAGE_GAP - 1)) begin
                        dom_d = dom_q & ~(N_DOM'(1) << idx_q);
                        gap_d = '0;
                        if (idx_q == IW'(N_DOM - 1)) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky cause and power-on flags; a new cause beats a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cause_q <= '0;
            por_q   <= 1'b1;
        end else begin
            cause_q <= (i_cause_clr ? '0 : cause_q) | rise;
            if (i_cause_clr) begin
                por_q <= 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        o_dom_rst  = dom_q;
        o_cause    = cause_q;
        o_por      = por_q;
        o_busy     = (state_q != ST_IDLE);
        o_rel_done = done_q;
    end

endmodule
